// File: rtl/div_unit.sv
// Iterative restoring radix-2 divider for the EX stage: decodes DIV/DIVU, stalls the pipeline
// while running, honours flush, and returns {remainder, quotient} for the HI/LO write.
module div_unit #(
  parameter int unsigned WIDTH           = 32,
  parameter logic [4:0]  ALUCONTROL_DIV  = 5'd14,
  parameter logic [4:0]  ALUCONTROL_DIVU = 5'd15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [4:0]           alucontrol,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 annul,
  output logic                 stall_div,
  output logic                 ready,
  output logic [2*WIDTH-1:0]   result
);

  localparam int unsigned CntW = $clog2(WIDTH) + 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e               state_q, state_d;
  logic                 signed_q, signed_d;
  logic                 q_neg_q, q_neg_d;
  logic                 r_neg_q, r_neg_d;
  logic [WIDTH-1:0]     dq_q, dq_d;    // dividend bits shift out, quotient bits shift in
  logic [WIDTH-1:0]     dvs_q, dvs_d;
  logic [WIDTH:0]       rem_q, rem_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic                 ready_q, ready_d;
  logic [2*WIDTH-1:0]   result_q, result_d;

  logic                 is_div, is_signed;
  logic [WIDTH-1:0]     a_abs, b_abs;
  logic [WIDTH+1:0]     shifted, trial;
  logic                 q_bit;
  logic [WIDTH:0]       rem_next;
  logic [WIDTH-1:0]     quo_next, q_final, r_final;

  assign is_div    = (alucontrol == ALUCONTROL_DIV) || (alucontrol == ALUCONTROL_DIVU);
  assign is_signed = (alucontrol == ALUCONTROL_DIV);
  assign a_abs     = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_abs     = (is_signed && b[WIDTH-1]) ? -b : b;

  assign shifted   = {rem_q, dq_q[WIDTH-1]};
  assign trial     = shifted - {2'b00, dvs_q};
  assign q_bit     = ~trial[WIDTH+1];
  assign rem_next  = q_bit ? trial[WIDTH:0] : shifted[WIDTH:0];
  assign quo_next  = {dq_q[WIDTH-2:0], q_bit};
  // MIN / -1 wraps naturally: magnitude 2^(WIDTH-1) negates back to MIN.
  assign q_final   = (signed_q && q_neg_q) ? -quo_next : quo_next;
  assign r_final   = (signed_q && r_neg_q) ? -rem_next[WIDTH-1:0] : rem_next[WIDTH-1:0];

  always_comb begin
    state_d  = state_q;
    signed_d = signed_q;
    q_neg_d  = q_neg_q;
    r_neg_d  = r_neg_q;
    dq_d     = dq_q;
    dvs_d    = dvs_q;
    rem_d    = rem_q;
    cnt_d    = cnt_q;
    ready_d  = 1'b0;
    result_d = result_q;
    case (state_q)
      StIdle: begin
        if (is_div && !annul) begin
          signed_d = is_signed;
          q_neg_d  = a[WIDTH-1] ^ b[WIDTH-1];
          r_neg_d  = a[WIDTH-1];
          dq_d     = a_abs;
          dvs_d    = b_abs;
          rem_d    = '0;
          cnt_d    = '0;
          if (b == '0) begin
            state_d  = StDone;
            ready_d  = 1'b1;
            result_d = {a, {WIDTH{1'b1}}};
          end else begin
            state_d  = StRun;
          end
        end
      end
      StRun: begin
        if (annul) begin
          state_d = StIdle;
        end else begin
          rem_d = rem_next;
          dq_d  = quo_next;
          cnt_d = cnt_q + CntW'(1);
          if (cnt_q == CntW'(WIDTH - 1)) begin
            state_d  = StDone;
            ready_d  = 1'b1;
            result_d = {r_final, q_final};
          end
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      signed_q <= 1'b0;
      q_neg_q  <= 1'b0;
      r_neg_q  <= 1'b0;
      dq_q     <= '0;
      dvs_q    <= '0;
      rem_q    <= '0;
      cnt_q    <= '0;
      ready_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      signed_q <= signed_d;
      q_neg_q  <= q_neg_d;
      r_neg_q  <= r_neg_d;
      dq_q     <= dq_d;
      dvs_q    <= dvs_d;
      rem_q    <= rem_d;
      cnt_q    <= cnt_d;
      ready_q  <= ready_d;
      result_q <= result_d;
    end
  end

  // Flush releases the pipeline in the same cycle it is raised.
  assign stall_div = ((state_q == StIdle) && is_div && !annul) || ((state_q == StRun) && !annul);
  assign ready     = ready_q;
  assign result    = result_q;

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit (WIDTH=32): latency, stall shape, signed/unsigned results,
// divide by zero, annul, async reset and back-to-back operation.
module tb_div_unit;

  localparam logic [4:0] OpDiv  = 5'd14;
  localparam logic [4:0] OpDivu = 5'd15;
  localparam logic [4:0] OpAdd  = 5'd2;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  alucontrol;
  logic [31:0] a, b;
  logic        annul;
  logic        stall_div, ready;
  logic [63:0] result;

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  div_unit #(
    .WIDTH           (32),
    .ALUCONTROL_DIV  (OpDiv),
    .ALUCONTROL_DIVU (OpDivu)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .alucontrol (alucontrol),
    .a          (a),
    .b          (b),
    .annul      (annul),
    .stall_div  (stall_div),
    .ready      (ready),
    .result     (result)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Called at posedge+1 of the accept cycle; returns at the negedge of the ready cycle.
  task automatic do_div(input string tag, input logic [4:0] op, input logic [31:0] ta,
                        input logic [31:0] tbv, input logic [63:0] exp, input int exp_lat);
    int  lat;
    int  stalls;
    bit  seen;
    lat = -1;
    stalls = 0;
    seen = 1'b0;
    alucontrol = op;
    a = ta;
    b = tbv;
    for (int i = 0; i < 100 && !seen; i++) begin
      @(negedge clk);
      if (ready) begin
        seen = 1'b1;
        lat = i;
      end else begin
        if (stall_div) stalls++;
        @(posedge clk);
        #1;
        if (i == 0) begin
          a = ~ta;
          b = '0;
        end
      end
    end
    check_eq({tag, "_lat"}, 64'(lat), 64'(exp_lat));
    check_eq({tag, "_stalls"}, 64'(stalls), 64'(exp_lat));
    check_eq({tag, "_stall_at_ready"}, 64'(stall_div), 64'd0);
    check_eq({tag, "_result"}, result, exp);
  endtask

  task automatic to_idle();
    alucontrol = OpAdd;
    @(posedge clk);
    #1;
  endtask

  int          r1, r2, ready_cnt;
  logic [63:0] held;

  initial begin
    rst = 1'b1;
    alucontrol = OpAdd;
    a = '0;
    b = '0;
    annul = 1'b0;
    #2;
    check_eq("rst_ready", 64'(ready), 64'd0);
    check_eq("rst_result", result, 64'd0);
    check_eq("rst_stall_nondiv", 64'(stall_div), 64'd0);
    alucontrol = OpDiv;
    #1;
    check_eq("rst_stall_div", 64'(stall_div), 64'd1);
    alucontrol = OpAdd;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Non-divide op: no stall, no ready.
    a = 32'd100;
    b = 32'd7;
    #3;
    check_eq("nondiv_stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    check_eq("nondiv_ready", 64'(ready), 64'd0);

    do_div("divu_100_7", OpDivu, 32'd100, 32'd7, {32'd2, 32'd14}, 33);
    to_idle();
    do_div("div_m7_2", OpDiv, 32'hFFFFFFF9, 32'd2, 64'hFFFFFFFF_FFFFFFFD, 33);
    to_idle();
    do_div("div_min_m1", OpDiv, 32'h80000000, 32'hFFFFFFFF, 64'h00000000_80000000, 33);
    to_idle();
    do_div("div_7_m2", OpDiv, 32'd7, 32'hFFFFFFFE, 64'h00000001_FFFFFFFD, 33);
    to_idle();
    do_div("divu_big", OpDivu, 32'h80000000, 32'hFFFFFFFF, 64'h80000000_00000000, 33);
    to_idle();
    do_div("divu_ff_16", OpDivu, 32'hFFFFFFFF, 32'd16, 64'h0000000F_0FFFFFFF, 33);
    to_idle();
    do_div("div_m8_0", OpDiv, 32'hFFFFFFF8, 32'd0, 64'hFFFFFFF8_FFFFFFFF, 1);
    to_idle();
    do_div("divu_by0", OpDivu, 32'h12345678, 32'd0, 64'h12345678_FFFFFFFF, 1);
    to_idle();

    // Annul together with a divide op in IDLE: not accepted.
    alucontrol = OpDiv;
    a = 32'd50;
    b = 32'd5;
    annul = 1'b1;
    #3;
    check_eq("idle_annul_stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    check_eq("idle_annul_ready", 64'(ready), 64'd0);
    check_eq("idle_annul_stall2", 64'(stall_div), 64'd0);
    annul = 1'b0;
    alucontrol = OpAdd;
    @(posedge clk);
    #1;

    // Annul at RUN cycle 10.
    held = result;
    alucontrol = OpDiv;
    a = 32'd100;
    b = 32'd7;
    for (int k = 0; k < 10; k++) begin
      @(posedge clk);
      #1;
    end
    check_eq("run_stall_pre_annul", 64'(stall_div), 64'd1);
    annul = 1'b1;
    #3;
    check_eq("annul_stall", 64'(stall_div), 64'd0);
    @(posedge clk);
    #1;
    annul = 1'b0;
    alucontrol = OpAdd;
    ready_cnt = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (ready) ready_cnt++;
    end
    check_eq("annul_no_ready", 64'(ready_cnt), 64'd0);
    check_eq("annul_result_held", result, held);
    @(posedge clk);
    #1;
    do_div("divu_9_3", OpDivu, 32'd9, 32'd3, {32'd0, 32'd3}, 33);
    to_idle();

    // Asynchronous reset mid-RUN.
    alucontrol = OpDivu;
    a = 32'd1000;
    b = 32'd3;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk);
      #1;
    end
    #2;
    alucontrol = OpAdd;
    rst = 1'b1;
    #1;
    check_eq("midrst_ready", 64'(ready), 64'd0);
    check_eq("midrst_result", result, 64'd0);
    check_eq("midrst_stall", 64'(stall_div), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    do_div("div_0_0", OpDiv, 32'd0, 32'd0, 64'h00000000_FFFFFFFF, 1);
    to_idle();
    do_div("after_rst", OpDivu, 32'd1000, 32'd3, {32'd1, 32'd333}, 33);
    to_idle();

    // Back-to-back with alucontrol changed in the DONE cycle.
    do_div("b2b_first", OpDivu, 32'd15, 32'd4, {32'd3, 32'd3}, 33);
    r1 = cyc;
    alucontrol = OpDiv;
    a = 32'hFFFFFFF1;
    b = 32'd4;
    @(posedge clk);
    #1;
    do_div("b2b_second", OpDiv, 32'hFFFFFFF1, 32'd4, 64'hFFFFFFFD_FFFFFFFD, 33);
    r2 = cyc;
    check_eq("b2b_spacing", 64'(r2 - r1), 64'd34);
    to_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
